// File: rtl/irq_sequencer_if.sv
// Pipeline-facing signal bundle for the interrupt/return sequencer.
// master = pipeline side (drives requests and context), slave = sequencer.
interface irq_sequencer_if #(
    parameter int W = 16
);
    // Requests and architectural context from the pipeline
    logic          interrupt;
    logic          hazard_stall;
    logic          rti_dec;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic [31:0]   pc_fd;
    logic [2:0]    flags_cur;

    // Pipeline control and injected micro-op
    logic          pc_enb;
    logic          f_d_enb;
    logic          flush_fd;
    logic          uop_valid;
    logic [2:0]    uop_sel;
    logic [W-1:0]  uop_data;
    logic          vec_load;
    logic          irq_active;
    logic          irq_pending;

    modport master (
        output interrupt, hazard_stall, rti_dec, branch_taken,
               branch_target, pc_fd, flags_cur,
        input  pc_enb, f_d_enb, flush_fd, uop_valid, uop_sel,
               uop_data, vec_load, irq_active, irq_pending
    );

    modport slave (
        input  interrupt, hazard_stall, rti_dec, branch_taken,
               branch_target, pc_fd, flags_cur,
        output pc_enb, f_d_enb, flush_fd, uop_valid, uop_sel,
               uop_data, vec_load, irq_active, irq_pending
    );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt / return-from-interrupt sequencer. Stalls Fetch, squashes F/D,
// lets older instructions drain, then injects the push series (IRQ) or the
// pop series (RTI) for the memory stage to execute.
// DRAIN_CYCLES must be at least 1. Requires W >= 16.
module irq_sequencer #(
    parameter int          W            = 16,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] VEC_ADDR     = 16'h0002
) (
    input  logic           clk,
    input  logic           rst,
    irq_sequencer_if.slave bus
);
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    localparam logic [2:0] SEL_PUSH_FL   = 3'd0;
    localparam logic [2:0] SEL_PUSH_PC_H = 3'd1;
    localparam logic [2:0] SEL_PUSH_PC_L = 3'd2;
    localparam logic [2:0] SEL_LOAD_VEC  = 3'd3;
    localparam logic [2:0] SEL_POP_PC_L  = 3'd4;
    localparam logic [2:0] SEL_POP_PC_H  = 3'd5;
    localparam logic [2:0] SEL_POP_FL    = 3'd6;

    typedef enum logic [3:0] {
        IDLE, I_DRAIN, I_FL, I_PCH, I_PCL, I_VEC,
        R_DRAIN, R_PCL, R_PCH, R_FL
    } state_t;

    state_t            state_reg, state_next;
    logic              irq_q_reg;
    logic              pending_reg, pending_next;
    logic [31:0]       saved_pc_reg, saved_pc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              irq_edge;
    logic [W-1:0]      uop_data_c;

    assign irq_edge = bus.interrupt & ~irq_q_reg;

    // State and sequencing context registers; reset returns to IDLE at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            irq_q_reg    <= 1'b0;
            pending_reg  <= 1'b0;
            saved_pc_reg <= 32'd0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            irq_q_reg    <= bus.interrupt;
            pending_reg  <= pending_next;
            saved_pc_reg <= saved_pc_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Next-state logic: entry arbitration, drain countdown, micro-op walk
    always_comb begin
        state_next    = state_reg;
        // An edge always lands in pending, even on the accepting cycle
        pending_next  = pending_reg | irq_edge;
        saved_pc_next = saved_pc_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            IDLE: begin
                // RTI wins over a pending interrupt; the interrupt stays latched
                if (bus.rti_dec && !bus.hazard_stall) begin
                    state_next = R_DRAIN;
                    cnt_next   = CNT_LOAD;
                end else if (pending_reg && !bus.hazard_stall) begin
                    state_next    = I_DRAIN;
                    pending_next  = irq_edge;
                    saved_pc_next = bus.branch_taken ? bus.branch_target : bus.pc_fd;
                    cnt_next      = CNT_LOAD;
                end
            end
            I_DRAIN: begin
                // A branch resolving while draining redirects the return PC
                if (bus.branch_taken) begin
                    saved_pc_next = bus.branch_target;
                end
                if (cnt_reg == '0) begin
                    state_next = I_FL;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            R_DRAIN: begin
                if (cnt_reg == '0) begin
                    state_next = R_PCL;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            I_FL:    state_next = I_PCH;
            I_PCH:   state_next = I_PCL;
            I_PCL:   state_next = I_VEC;
            I_VEC:   state_next = IDLE;
            R_PCL:   state_next = R_PCH;
            R_PCH:   state_next = R_FL;
            R_FL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore output decode from the current state
    always_comb begin
        bus.pc_enb     = 1'b1;
        bus.f_d_enb    = 1'b1;
        bus.flush_fd   = 1'b0;
        bus.uop_valid  = 1'b0;
        bus.uop_sel    = 3'd0;
        bus.vec_load   = 1'b0;
        bus.irq_active = 1'b0;
        uop_data_c     = '0;
        if (state_reg != IDLE) begin
            bus.pc_enb     = 1'b0;
            bus.f_d_enb    = 1'b0;
            bus.irq_active = 1'b1;
        end
        case (state_reg)
            I_DRAIN, R_DRAIN: begin
                bus.flush_fd = (cnt_reg == CNT_LOAD);
            end
            I_FL: begin
                bus.uop_valid   = 1'b1;
                bus.uop_sel     = SEL_PUSH_FL;
                uop_data_c[2:0] = bus.flags_cur;
            end
            I_PCH: begin
                bus.uop_valid    = 1'b1;
                bus.uop_sel      = SEL_PUSH_PC_H;
                uop_data_c[15:0] = saved_pc_reg[31:16];
            end
            I_PCL: begin
                bus.uop_valid    = 1'b1;
                bus.uop_sel      = SEL_PUSH_PC_L;
                uop_data_c[15:0] = saved_pc_reg[15:0];
            end
            I_VEC: begin
                bus.uop_valid    = 1'b1;
                bus.uop_sel      = SEL_LOAD_VEC;
                uop_data_c[15:0] = VEC_ADDR;
                bus.vec_load     = 1'b1;
            end
            R_PCL: begin
                bus.uop_valid = 1'b1;
                bus.uop_sel   = SEL_POP_PC_L;
            end
            R_PCH: begin
                bus.uop_valid = 1'b1;
                bus.uop_sel   = SEL_POP_PC_H;
            end
            R_FL: begin
                bus.uop_valid = 1'b1;
                bus.uop_sel   = SEL_POP_FL;
            end
            default: ;
        endcase
    end

    assign bus.uop_data    = uop_data_c;
    assign bus.irq_pending = pending_reg;

endmodule

// File: tb/tb_irq_sequencer.sv
// Table-driven bench for irq_sequencer: per-cycle {inputs, expected outputs}
// records, expectations queued at drive time and checked at the falling edge.
module tb_irq_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    irq_sequencer_if #(.W(16)) bus ();

    irq_sequencer #(
        .W(16), .DRAIN_CYCLES(3), .VEC_ADDR(16'h0002)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_enb;
        logic        f_d_enb;
        logic        flush_fd;
        logic        uop_valid;
        logic [2:0]  uop_sel;
        logic [15:0] uop_data;
        logic        vec_load;
        logic        irq_active;
        logic        irq_pending;
    } out_t;

    typedef struct {
        string       tag;
        logic        intr;
        logic        hz;
        logic        rti;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [2:0]  fl;
        out_t        exp;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   idx   = 0;
    out_t exp_q[$];
    vec_t tbl[$];

    // Input values captured by add() for the next table row
    logic        c_intr = 0, c_hz = 0, c_rti = 0, c_br = 0;
    logic [31:0] c_tgt = 0, c_pc = 0;
    logic [2:0]  c_fl = 0;

    function automatic out_t o_idle(logic p);
        out_t o;
        o = '0;
        o.pc_enb = 1'b1;
        o.f_d_enb = 1'b1;
        o.irq_pending = p;
        return o;
    endfunction

    function automatic out_t o_drain(logic first, logic p);
        out_t o;
        o = '0;
        o.flush_fd = first;
        o.irq_active = 1'b1;
        o.irq_pending = p;
        return o;
    endfunction

    function automatic out_t o_uop(logic [2:0] sel, logic [15:0] data, logic p);
        out_t o;
        o = '0;
        o.uop_valid = 1'b1;
        o.uop_sel = sel;
        o.uop_data = data;
        o.vec_load = (sel == 3'd3);
        o.irq_active = 1'b1;
        o.irq_pending = p;
        return o;
    endfunction

    function automatic void add(string tag, out_t e);
        vec_t v;
        v.tag = tag; v.intr = c_intr; v.hz = c_hz; v.rti = c_rti; v.br = c_br;
        v.tgt = c_tgt; v.pc = c_pc; v.fl = c_fl; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic out_t get_out();
        out_t o;
        o.pc_enb = bus.pc_enb;
        o.f_d_enb = bus.f_d_enb;
        o.flush_fd = bus.flush_fd;
        o.uop_valid = bus.uop_valid;
        o.uop_sel = bus.uop_sel;
        o.uop_data = bus.uop_data;
        o.vec_load = bus.vec_load;
        o.irq_active = bus.irq_active;
        o.irq_pending = bus.irq_pending;
        return o;
    endfunction

    task automatic drive(input vec_t v);
        bus.interrupt = v.intr;
        bus.hazard_stall = v.hz;
        bus.rti_dec = v.rti;
        bus.branch_taken = v.br;
        bus.branch_target = v.tgt;
        bus.pc_fd = v.pc;
        bus.flags_cur = v.fl;
        exp_q.push_back(v.exp);
    endtask

    task automatic check(input string tag);
        out_t e, g;
        e = exp_q.pop_front();
        g = get_out();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s[%0d] got pc_enb=%b fd=%b fl=%b uv=%b sel=%0d data=%h vl=%b act=%b pend=%b want pc_enb=%b fd=%b fl=%b uv=%b sel=%0d data=%h vl=%b act=%b pend=%b",
                     tag, idx, g.pc_enb, g.f_d_enb, g.flush_fd, g.uop_valid, g.uop_sel,
                     g.uop_data, g.vec_load, g.irq_active, g.irq_pending,
                     e.pc_enb, e.f_d_enb, e.flush_fd, e.uop_valid, e.uop_sel,
                     e.uop_data, e.vec_load, e.irq_active, e.irq_pending);
        end else begin
            $display("ok   %s[%0d] pc_enb=%b flush=%b uv=%b sel=%0d data=%h vl=%b act=%b pend=%b",
                     tag, idx, g.pc_enb, g.flush_fd, g.uop_valid, g.uop_sel,
                     g.uop_data, g.vec_load, g.irq_active, g.irq_pending);
        end
        idx++;
    endtask

    // Apply every row: drive after the rising edge, check at the falling edge
    task automatic run_table(input bit hold_last);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check(tbl[i].tag);
            if (!(hold_last && i == tbl.size() - 1)) begin
                @(posedge clk);
                #1;
            end
        end
        tbl.delete();
    endtask

    initial begin
        bus.interrupt = 0; bus.hazard_stall = 0; bus.rti_dec = 0;
        bus.branch_taken = 0; bus.branch_target = 0; bus.pc_fd = 0; bus.flags_cur = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(o_idle(1'b0));
        check("RST");
        rst = 0;
        @(posedge clk);
        #1;

        // A: basic IRQ; pc_fd changes after capture to prove it was latched
        c_pc = 32'h0000_0120; c_fl = 3'b101; c_intr = 1; add("A", o_idle(0));
        c_intr = 0; add("A", o_idle(1));
        add("A", o_drain(1, 0));
        c_pc = 32'h0000_0999; add("A", o_drain(0, 0)); add("A", o_drain(0, 0));
        add("A", o_uop(0, 16'h0005, 0)); add("A", o_uop(1, 16'h0000, 0));
        add("A", o_uop(2, 16'h0120, 0)); add("A", o_uop(3, 16'h0002, 0));
        add("A", o_idle(0));

        // B: branch taken in the second drain cycle redirects saved PC
        c_pc = 32'h0000_0010; c_fl = 3'b010; c_intr = 1; add("B", o_idle(0));
        c_intr = 0; add("B", o_idle(1));
        add("B", o_drain(1, 0));
        c_br = 1; c_tgt = 32'h0001_0400; add("B", o_drain(0, 0));
        c_br = 0; c_tgt = 0; add("B", o_drain(0, 0));
        add("B", o_uop(0, 16'h0002, 0)); add("B", o_uop(1, 16'h0001, 0));
        add("B", o_uop(2, 16'h0400, 0)); add("B", o_uop(3, 16'h0002, 0));
        add("B", o_idle(0));

        // C: RTI and pending together; RTI first, stall ignored mid-sequence
        c_pc = 32'h0000_abcd; c_fl = 3'b011; c_intr = 1; add("C", o_idle(0));
        c_intr = 0; c_rti = 1; add("C", o_idle(1));
        c_rti = 0; add("C", o_drain(1, 1));
        c_hz = 1; add("C", o_drain(0, 1));
        c_hz = 0; add("C", o_drain(0, 1));
        add("C", o_uop(4, 0, 1)); add("C", o_uop(5, 0, 1)); add("C", o_uop(6, 0, 1));
        add("C", o_idle(1));
        add("C", o_drain(1, 0)); add("C", o_drain(0, 0)); add("C", o_drain(0, 0));
        add("C", o_uop(0, 16'h0003, 0)); add("C", o_uop(1, 16'h0000, 0));
        add("C", o_uop(2, 16'habcd, 0)); add("C", o_uop(3, 16'h0002, 0));
        add("C", o_idle(0));

        // D: hazard stall holds entry 2 cycles (also blocks RTI); branch at entry
        c_pc = 32'h0000_0055; c_fl = 3'b110; c_intr = 1; add("D", o_idle(0));
        c_intr = 0; c_hz = 1; c_rti = 1; add("D", o_idle(1)); add("D", o_idle(1));
        c_hz = 0; c_rti = 0; c_br = 1; c_tgt = 32'h0002_0030; add("D", o_idle(1));
        c_br = 0; c_tgt = 0; add("D", o_drain(1, 0));
        c_hz = 1; add("D", o_drain(0, 0));
        c_hz = 0; add("D", o_drain(0, 0));
        add("D", o_uop(0, 16'h0006, 0)); add("D", o_uop(1, 16'h0002, 0));
        add("D", o_uop(2, 16'h0030, 0)); add("D", o_uop(3, 16'h0002, 0));
        add("D", o_idle(0));

        // F: edge during drain is held and starts a second sequence after IDLE
        c_pc = 32'h0000_0300; c_fl = 3'b001; c_intr = 1; add("F", o_idle(0));
        c_intr = 0; add("F", o_idle(1));
        add("F", o_drain(1, 0));
        c_intr = 1; add("F", o_drain(0, 0));
        c_intr = 0; add("F", o_drain(0, 1));
        add("F", o_uop(0, 16'h0001, 1)); add("F", o_uop(1, 16'h0000, 1));
        add("F", o_uop(2, 16'h0300, 1)); add("F", o_uop(3, 16'h0002, 1));
        add("F", o_idle(1));
        add("F", o_drain(1, 0)); add("F", o_drain(0, 0)); add("F", o_drain(0, 0));
        add("F", o_uop(0, 16'h0001, 0)); add("F", o_uop(1, 16'h0000, 0));
        add("F", o_uop(2, 16'h0300, 0)); add("F", o_uop(3, 16'h0002, 0));
        add("F", o_idle(0));

        // E: interrupt level-high for 20 cycles gives exactly one sequence
        c_pc = 32'h0000_0200; c_fl = 3'b000; c_intr = 1; add("E", o_idle(0));
        add("E", o_idle(1));
        add("E", o_drain(1, 0)); add("E", o_drain(0, 0)); add("E", o_drain(0, 0));
        add("E", o_uop(0, 16'h0000, 0)); add("E", o_uop(1, 16'h0000, 0));
        add("E", o_uop(2, 16'h0200, 0)); add("E", o_uop(3, 16'h0002, 0));
        for (int k = 0; k < 11; k++) add("E", o_idle(0));
        c_intr = 0; add("E", o_idle(0)); add("E", o_idle(0));
        run_table(1'b0);

        // R: reset asserted while in I_PCH with a second interrupt pending
        c_pc = 32'h0000_7777; c_fl = 3'b000; c_intr = 1; add("R", o_idle(0));
        c_intr = 0; add("R", o_idle(1));
        add("R", o_drain(1, 0));
        c_intr = 1; add("R", o_drain(0, 0));
        c_intr = 0; add("R", o_drain(0, 1));
        add("R", o_uop(0, 16'h0000, 1)); add("R", o_uop(1, 16'h0000, 1));
        run_table(1'b1);
        #1 rst = 1;
        #1;
        exp_q.push_back(o_idle(1'b0));
        check("RSTMID");
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        c_intr = 0;
        for (int k = 0; k < 6; k++) add("POST", o_idle(0));
        run_table(1'b0);

        // H: interrupt held high through reset release counts as an edge
        bus.interrupt = 1;
        rst = 1;
        @(negedge clk);
        exp_q.push_back(o_idle(1'b0));
        check("RSTH");
        #1 rst = 0;
        @(posedge clk);
        #1;
        c_intr = 1; c_pc = 32'h0000_4444; c_fl = 3'b111; add("H", o_idle(1));
        add("H", o_drain(1, 0)); add("H", o_drain(0, 0)); add("H", o_drain(0, 0));
        add("H", o_uop(0, 16'h0007, 0)); add("H", o_uop(1, 16'h0000, 0));
        add("H", o_uop(2, 16'h4444, 0)); add("H", o_uop(3, 16'h0002, 0));
        add("H", o_idle(0)); add("H", o_idle(0));
        run_table(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
